// File: rtl/proc_mem_arb.sv
// Round-robin arbiter merging the fetch and data memory ports onto one memory port.
// Responses return in order and are steered back by a FIFO of 1-bit requester tags.
package proc_mem_arb_pkg;
  typedef struct packed {
    logic [2:0]  msg_type;
    logic [7:0]  opaque;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_req_4B_t;

  typedef struct packed {
    logic [2:0]  msg_type;
    logic [7:0]  opaque;
    logic [1:0]  test;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_resp_4B_t;
endpackage

module proc_mem_arb
  import proc_mem_arb_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  mem_req_4B_t                          imemreq_msg,
  input  logic                                 imemreq_val,
  output logic                                 imemreq_rdy,
  output mem_resp_4B_t                         imemresp_msg,
  output logic                                 imemresp_val,
  input  logic                                 imemresp_rdy,
  input  mem_req_4B_t                          dmemreq_msg,
  input  logic                                 dmemreq_val,
  output logic                                 dmemreq_rdy,
  output mem_resp_4B_t                         dmemresp_msg,
  output logic                                 dmemresp_val,
  input  logic                                 dmemresp_rdy,
  output mem_req_4B_t                          memreq_msg,
  output logic                                 memreq_val,
  input  logic                                 memreq_rdy,
  input  mem_resp_4B_t                         memresp_msg,
  input  logic                                 memresp_val,
  output logic                                 memresp_rdy,
  output logic [$clog2(MAX_OUTSTANDING):0]     outstanding,
  output logic                                 resp_err
);

  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;

  logic              last_grant_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic              resp_err_reg;
  logic              tag_mem [MAX_OUTSTANDING];

  logic fifo_full;
  logic fifo_empty;
  logic sel_valid;
  logic sel_id;
  logic head_id;
  logic push;
  logic pop;

  assign fifo_full  = (count_reg == CNT_W'(MAX_OUTSTANDING));
  assign fifo_empty = (count_reg == '0);

  // Grant depends only on registered state and request vals, never on memreq_rdy.
  always_comb begin
    sel_valid = 1'b0;
    sel_id    = 1'b0;
    if (reset_n && !fifo_full) begin
      if (imemreq_val && dmemreq_val) begin
        sel_valid = 1'b1;
        sel_id    = ~last_grant_reg;
      end else if (imemreq_val) begin
        sel_valid = 1'b1;
      end else if (dmemreq_val) begin
        sel_valid = 1'b1;
        sel_id    = 1'b1;
      end
    end
  end

  assign memreq_msg  = sel_id ? dmemreq_msg : imemreq_msg;
  assign memreq_val  = sel_valid;
  assign imemreq_rdy = sel_valid & ~sel_id & memreq_rdy;
  assign dmemreq_rdy = sel_valid &  sel_id & memreq_rdy;

  assign head_id      = tag_mem[rd_ptr_reg];
  assign imemresp_msg = memresp_msg;
  assign dmemresp_msg = memresp_msg;
  assign imemresp_val = ~fifo_empty & ~head_id & memresp_val;
  assign dmemresp_val = ~fifo_empty &  head_id & memresp_val;
  // With nothing outstanding the memory side is drained so a stray response cannot stall it.
  assign memresp_rdy  = fifo_empty | (head_id ? dmemresp_rdy : imemresp_rdy);

  assign push = memreq_val & memreq_rdy;
  assign pop  = memresp_val & memresp_rdy & ~fifo_empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_reg <= 1'b1;
      rd_ptr_reg     <= '0;
      wr_ptr_reg     <= '0;
      count_reg      <= '0;
      resp_err_reg   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg     <= wr_ptr_reg + PTR_W'(1);
        last_grant_reg <= sel_id;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
      if (fifo_empty && memresp_val) begin
        resp_err_reg <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      tag_mem[wr_ptr_reg] <= sel_id;
    end
  end

  assign outstanding = count_reg;
  assign resp_err    = resp_err_reg;

endmodule

// File: tb/tb_proc_mem_arb.sv
// Randomized bench for proc_mem_arb: queue-based model of grants, tags and in-order memory.
module tb_proc_mem_arb;
  import proc_mem_arb_pkg::*;

  localparam int MAX = 4;

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  mem_req_4B_t  imemreq_msg, dmemreq_msg, memreq_msg;
  logic         imemreq_val, imemreq_rdy, dmemreq_val, dmemreq_rdy;
  mem_resp_4B_t imemresp_msg, dmemresp_msg, memresp_msg;
  logic         imemresp_val, imemresp_rdy, dmemresp_val, dmemresp_rdy;
  logic         memreq_val, memreq_rdy, memresp_val, memresp_rdy;
  logic [2:0]   outstanding;
  logic         resp_err;

  proc_mem_arb #(.MAX_OUTSTANDING(MAX)) dut (
    .clk(clk), .reset_n(reset_n),
    .imemreq_msg(imemreq_msg), .imemreq_val(imemreq_val), .imemreq_rdy(imemreq_rdy),
    .imemresp_msg(imemresp_msg), .imemresp_val(imemresp_val), .imemresp_rdy(imemresp_rdy),
    .dmemreq_msg(dmemreq_msg), .dmemreq_val(dmemreq_val), .dmemreq_rdy(dmemreq_rdy),
    .dmemresp_msg(dmemresp_msg), .dmemresp_val(dmemresp_val), .dmemresp_rdy(dmemresp_rdy),
    .memreq_msg(memreq_msg), .memreq_val(memreq_val), .memreq_rdy(memreq_rdy),
    .memresp_msg(memresp_msg), .memresp_val(memresp_val), .memresp_rdy(memresp_rdy),
    .outstanding(outstanding), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: owner of every outstanding request in order, plus memory contents.
  bit           m_lg;
  bit           m_tags[$];
  bit           m_err;
  mem_resp_4B_t m_memq[$];
  logic [31:0]  m_iexp[$];
  logic [31:0]  m_dexp[$];

  bit          i_pend, d_pend;
  mem_req_4B_t i_msg, d_msg;
  bit          got_i, got_d;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a == 32'h200) ? 32'hDEADBEEF : (a ^ 32'h5A5A_5A5A);
  endfunction

  function automatic mem_req_4B_t rand_req(input logic [31:0] a);
    mem_req_4B_t r;
    r.msg_type = 3'($urandom_range(0, 1));
    r.opaque   = 8'($urandom);
    r.addr     = a;
    r.len      = 2'b00;
    r.data     = $urandom;
    return r;
  endfunction

  task automatic drive(input bit mv, input bit mrdy, input bit irdy, input bit drdy);
    mem_resp_4B_t r;
    imemreq_val  = i_pend;
    imemreq_msg  = i_msg;
    dmemreq_val  = d_pend;
    dmemreq_msg  = d_msg;
    memreq_rdy   = mrdy;
    imemresp_rdy = irdy;
    dmemresp_rdy = drdy;
    memresp_val  = mv;
    if (m_memq.size() > 0) begin
      memresp_msg = m_memq[0];
    end else begin
      r = '0;
      r.opaque = 8'($urandom);
      r.data = $urandom;
      memresp_msg = r;
    end
  endtask

  // Check all outputs mid-cycle against the model, then advance the model by one clock.
  task automatic step();
    bit full, empty, sv, sid, head, exp_iv, exp_dv, exp_mr;
    mem_req_4B_t  smsg;
    mem_resp_4B_t r;
    @(negedge clk);
    full  = (m_tags.size() == MAX);
    empty = (m_tags.size() == 0);
    sv = 1'b0;
    sid = 1'b0;
    if (!full) begin
      if (i_pend && d_pend) begin sv = 1'b1; sid = ~m_lg; end
      else if (i_pend) sv = 1'b1;
      else if (d_pend) begin sv = 1'b1; sid = 1'b1; end
    end
    smsg = sid ? d_msg : i_msg;
    check("memreq_val", memreq_val, sv);
    if (sv) check("memreq_msg", memreq_msg, smsg);
    check("imemreq_rdy", imemreq_rdy, sv && !sid && memreq_rdy);
    check("dmemreq_rdy", dmemreq_rdy, sv && sid && memreq_rdy);
    head   = empty ? 1'b0 : m_tags[0];
    exp_iv = !empty && !head && memresp_val;
    exp_dv = !empty && head && memresp_val;
    exp_mr = empty ? 1'b1 : (head ? dmemresp_rdy : imemresp_rdy);
    check("imemresp_val", imemresp_val, exp_iv);
    check("dmemresp_val", dmemresp_val, exp_dv);
    check("memresp_rdy", memresp_rdy, exp_mr);
    check("outstanding", outstanding, m_tags.size());
    check("resp_err", resp_err, m_err);
    check("imemresp_msg", imemresp_msg, memresp_msg);
    check("dmemresp_msg", dmemresp_msg, memresp_msg);

    got_i = 1'b0;
    got_d = 1'b0;
    if (!empty && memresp_val && exp_mr) begin
      void'(m_tags.pop_front());
      if (head) check("dmem_data", dmemresp_msg.data, m_dexp.pop_front());
      else      check("imem_data", imemresp_msg.data, m_iexp.pop_front());
      if (m_memq.size() > 0) void'(m_memq.pop_front());
    end
    if (empty && memresp_val) m_err = 1'b1;
    if (sv && memreq_rdy) begin
      m_tags.push_back(sid);
      m_lg = sid;
      r.msg_type = smsg.msg_type;
      r.opaque   = smsg.opaque;
      r.test     = 2'b00;
      r.len      = smsg.len;
      r.data     = mem_data(smsg.addr);
      m_memq.push_back(r);
      if (sid) begin m_dexp.push_back(r.data); got_d = 1'b1; d_pend = 1'b0; end
      else     begin m_iexp.push_back(r.data); got_i = 1'b1; i_pend = 1'b0; end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cycle(input bit mv, input bit mrdy, input bit irdy, input bit drdy);
    drive(mv, mrdy, irdy, drdy);
    step();
  endtask

  // Asserts reset between clock edges and checks that state clears without a clock.
  task automatic do_reset();
    #2;
    imemreq_val = 1'b1;
    dmemreq_val = 1'b1;
    memreq_rdy  = 1'b1;
    memresp_val = 1'b1;
    imemresp_rdy = 1'b1;
    dmemresp_rdy = 1'b1;
    reset_n = 1'b0;
    #1;
    check("rst_outstanding", outstanding, 0);
    check("rst_resp_err", resp_err, 0);
    check("rst_memreq_val", memreq_val, 0);
    check("rst_imemreq_rdy", imemreq_rdy, 0);
    check("rst_dmemreq_rdy", dmemreq_rdy, 0);
    check("rst_imemresp_val", imemresp_val, 0);
    check("rst_dmemresp_val", dmemresp_val, 0);
    check("rst_memresp_rdy", memresp_rdy, 1);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    m_lg = 1'b1;
    m_tags.delete();
    m_memq.delete();
    m_iexp.delete();
    m_dexp.delete();
    m_err = 1'b0;
    i_pend = 1'b0;
    d_pend = 1'b0;
  endtask

  initial begin
    i_pend = 1'b0;
    d_pend = 1'b0;
    i_msg = '0;
    d_msg = '0;
    drive(0, 0, 0, 0);
    do_reset();

    // Single fetch to 0x200, answered with 0xDEADBEEF.
    i_pend = 1'b1;
    i_msg = rand_req(32'h200);
    cycle(0, 1, 1, 1);
    check("fetch_grant", got_i, 1);
    cycle(1, 1, 1, 1);
    cycle(0, 1, 1, 1);

    // Conflict fairness: both requesting continuously, responses one cycle later.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      if (!i_pend) begin i_pend = 1'b1; i_msg = rand_req(32'h1000 + 32'(k * 4)); end
      if (!d_pend) begin d_pend = 1'b1; d_msg = rand_req(32'h8000 + 32'(k * 4)); end
      cycle(m_memq.size() > 0, 1, 1, 1);
      check("fair_grant_i", got_i, (k % 2) == 0);
      check("fair_grant_d", got_d, (k % 2) == 1);
    end
    i_pend = 1'b0;
    d_pend = 1'b0;
    repeat (3) cycle(m_memq.size() > 0, 1, 1, 1);

    // Full FIFO blocks requests; a pop does not free a slot in the same cycle.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      i_pend = 1'b1;
      i_msg = rand_req(32'h2000 + 32'(k * 4));
      cycle(0, 1, 1, 1);
    end
    i_pend = 1'b1;
    i_msg = rand_req(32'h2100);
    cycle(0, 1, 1, 1);
    check("full_block", got_i, 0);
    check("full_count", outstanding, 4);
    cycle(1, 1, 1, 1);
    check("full_pop_no_push", got_i, 0);
    cycle(0, 1, 1, 1);
    check("full_push_next", got_i, 1);

    // Simultaneous push and pop keeps the count.
    do_reset();
    d_pend = 1'b1; d_msg = rand_req(32'h3000); cycle(0, 1, 1, 1);
    i_pend = 1'b1; i_msg = rand_req(32'h3004); cycle(0, 1, 1, 1);
    d_pend = 1'b1; d_msg = rand_req(32'h3008); cycle(1, 1, 1, 1);
    check("pushpop_grant", got_d, 1);
    check("pushpop_count", outstanding, 2);

    // Response backpressure on the data port.
    do_reset();
    d_pend = 1'b1; d_msg = rand_req(32'h4000); cycle(0, 1, 1, 1);
    repeat (3) cycle(1, 1, 1, 0);
    check("bp_hold", outstanding, 1);
    cycle(1, 1, 1, 1);
    check("bp_pop", outstanding, 0);

    // Spurious response sets the sticky error; async reset clears it with 3 outstanding.
    do_reset();
    cycle(1, 0, 1, 1);
    cycle(0, 0, 1, 1);
    for (int k = 0; k < 3; k++) begin
      i_pend = 1'b1;
      i_msg = rand_req(32'h5000 + 32'(k * 4));
      cycle(0, 1, 1, 1);
    end
    check("pre_reset_count", outstanding, 3);
    check("pre_reset_err", resp_err, 1);
    do_reset();

    // Random mixed traffic across many pointer wraps.
    for (int n = 0; n < 600; n++) begin
      bit mv;
      if (!i_pend && $urandom_range(0, 2) != 0) begin i_pend = 1'b1; i_msg = rand_req($urandom & 32'hFFFF_FFFC); end
      if (!d_pend && $urandom_range(0, 2) != 0) begin d_pend = 1'b1; d_msg = rand_req($urandom & 32'hFFFF_FFFC); end
      mv = (m_memq.size() > 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 99) == 0);
      cycle(mv, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    end
    i_pend = 1'b0;
    d_pend = 1'b0;
    repeat (8) cycle(m_memq.size() > 0, 1, 1, 1);
    check("drain_count", outstanding, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
